// File: rtl/event_serializer.sv
// -----------------------------------------------------------------------------
// event_serializer
//
// Purpose:
//   Takes packed DVS event words from a show-ahead sync_fifo and sends them
//   downstream as a stream of OWIDTH-bit beats, most significant beat first,
//   over a valid/ready handshake. When the next word is already waiting at a
//   word boundary, it is loaded in the same cycle as the last beat is
//   accepted, so consecutive words go out with no idle cycle between them.
//
// Parameters:
//   DWIDTH     - width of one FIFO word (one packed event); default 64.
//   OWIDTH     - width of one output beat; DWIDTH must be a whole multiple.
//
// Ports:
//   clk        - single clock, rising-edge active.
//   rst_n      - asynchronous active-low reset.
//   en         - permits starting a new word; looked at only on word boundaries.
//   fifo_empty - upstream FIFO empty flag.
//   fifo_rdata - upstream FIFO head word, valid whenever fifo_empty is low.
//   fifo_rd_en - pops the FIFO head at the next rising edge (combinational).
//   out_data   - current output beat.
//   out_valid  - out_data is valid.
//   out_ready  - downstream accepts the beat when valid and ready are both high.
//   out_last   - marks the final beat of a word.
//   busy       - high whenever the block is not idle.
//   word_cnt   - count of fully transmitted words, wraps at 16 bits.
// -----------------------------------------------------------------------------
module event_serializer #(
  parameter int DWIDTH = 64,
  parameter int OWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam int NBEATS = DWIDTH / OWIDTH;
  // Beat index width; a single-beat word still needs a one-bit index.
  localparam int IW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [15:0]       word_cnt_q, word_cnt_d;

  logic accept_s;
  logic last_s;
  logic load_s;

  // Handshake and word-boundary qualifiers shared by the next-state logic and
  // the outputs.
  always_comb begin
    accept_s = (state_q == S_SEND) && out_ready;
    last_s   = (state_q == S_SEND) && (idx_q == LAST_IDX);
    // A new word may be taken only when idle or as the last beat leaves.
    // rst_n gates the pop so nothing is read from the FIFO while reset is
    // held, even though the state register alone would already be idle.
    if (rst_n && en && !fifo_empty &&
        ((state_q == S_IDLE) || (accept_s && last_s))) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE/SEND machine, shift register, beat index
  // and completed-word counter.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_s) begin
          state_d = S_SEND;
          shreg_d = fifo_rdata;
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (accept_s) begin
          if (last_s) begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (load_s) begin
              // Back-to-back: next word replaces the drained one directly.
              state_d = S_SEND;
              shreg_d = fifo_rdata;
              idx_d   = {IW{1'b0}};
            end else begin
              // Shifting the last beat out leaves the register all-zero, so
              // out_data reads 0 while idle.
              state_d = S_IDLE;
              shreg_d = shreg_q << OWIDTH;
              idx_d   = {IW{1'b0}};
            end
          end else begin
            shreg_d = shreg_q << OWIDTH;
            idx_d   = idx_q + IW'(1);
          end
        end else begin
          // Stalled: beat, index and flags hold.
          state_d = S_SEND;
        end
      end
      default: begin
        state_d    = S_IDLE;
        shreg_d    = {DWIDTH{1'b0}};
        idx_d      = {IW{1'b0}};
        word_cnt_d = word_cnt_q;
      end
    endcase
  end

  // State, shift register, beat index and word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= {DWIDTH{1'b0}};
      idx_q      <= {IW{1'b0}};
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // All outputs except the pop strobe come straight from registers (or a
  // compare of registers), so they drop to 0 as soon as reset asserts.
  assign out_data   = shreg_q[DWIDTH-1 -: OWIDTH];
  assign out_valid  = (state_q == S_SEND);
  assign out_last   = last_s;
  assign busy       = (state_q != S_IDLE);
  assign word_cnt   = word_cnt_q;
  assign fifo_rd_en = load_s;

endmodule

// File: tb/tb_event_serializer.sv
// -----------------------------------------------------------------------------
// tb_event_serializer
//
// Randomized scoreboard bench for event_serializer. A queue-based FIFO model
// feeds the DUT; every word written to it is also queued as an expected word.
// A monitor slices expected words into MSB-first beats with plain arithmetic
// and compares every beat the DUT presents, plus stall stability, out_last,
// and the running word count.
// -----------------------------------------------------------------------------
module tb_event_serializer;

  localparam int DW = 64;
  localparam int OW = 8;
  localparam int NB = DW / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd_en;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic [15:0]   word_cnt;

  event_serializer #(.DWIDTH(DW), .OWIDTH(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            pop_cnt = 0;
  logic [15:0]   model_cnt = 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fifo_update();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_update();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: sample the pop strobe mid-cycle, apply it just after the edge.
  logic pop_s;
  always begin
    @(negedge clk);
    pop_s = fifo_rd_en;
    if (fifo_rd_en) begin
      pop_cnt++;
      check("rd_en_only_when_nonempty", fifo_empty, 1'b0);
    end
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      fifo_update();
    end
  end

  // Monitor / scoreboard.
  int            mon_idx = 0;
  logic          in_word = 1'b0;
  logic          stalled = 1'b0;
  logic [OW-1:0] stall_data = '0;
  logic [DW-1:0] cur_word = '0;
  logic [OW-1:0] exp_beat;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // A word cut short by reset is gone for good.
      mon_idx   = 0;
      in_word   = 1'b0;
      stalled   = 1'b0;
      model_cnt = 16'd0;
    end else if (!clk) begin
      check("word_cnt", word_cnt, model_cnt);
      if (in_word) check("valid_held_mid_word", out_valid, 1'b1);
      if (stalled) check("stall_data_stable", out_data, stall_data);
      stalled = 1'b0;
      if (out_valid) begin
        if (!in_word) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_word: got beat %0h, expected no output", out_data);
            cur_word = '0;
          end else begin
            cur_word = exp_q.pop_front();
          end
          in_word = 1'b1;
        end
        exp_beat = cur_word[DW-1 - mon_idx*OW -: OW];
        check("beat_data", out_data, exp_beat);
        check("out_last", out_last, (mon_idx == NB - 1));
        if (out_ready) begin
          mon_idx++;
          if (mon_idx == NB) begin
            mon_idx   = 0;
            in_word   = 1'b0;
            model_cnt = model_cnt + 16'd1;
          end
        end else begin
          stalled    = 1'b1;
          stall_data = out_data;
        end
      end else begin
        check("idle_last_low", out_last, 1'b0);
      end
    end
  end

  // Wait for busy to rise, then count valid cycles until it falls.
  task automatic run_word_phase(input string name, input int bound, output int vcyc);
    int n;
    n = 0;
    vcyc = 0;
    while (!busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    while (busy && n < bound) begin
      if (out_valid) vcyc++;
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got no return to idle, expected within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_beats(input int nbeats, input int bound);
    int cnt;
    int n;
    cnt = 0;
    n = 0;
    while (cnt < nbeats && n < bound) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) cnt++;
    end
    if (cnt < nbeats) begin
      checks++;
      fails++;
      $display("FAIL wait_beats_timeout: got %0d beats, expected %0d", cnt, nbeats);
    end
  endtask

  initial begin
    int vcyc;
    int pops0;
    int i;
    fifo_update();

    // Reset with en high and a non-empty FIFO: nothing may move.
    rst_n = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;
    push_word(64'h0123456789ABCDEF);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    check("rst_word_cnt", word_cnt, 16'h0000);

    // en=0 with data waiting: no pop, no output.
    tick();
    en = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("en0_no_pop", pop_cnt, 0);
    check("en0_no_valid", out_valid, 1'b0);

    // Single word, latency and throughput.
    tick();
    en = 1'b1;
    @(negedge clk);
    check("lat_rd_en_cycle_n", fifo_rd_en, 1'b1);
    check("lat_valid_low_cycle_n", out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid_cycle_n1", out_valid, 1'b1);
    check("lat_first_beat", out_data, 8'h01);
    run_word_phase("single", 50, vcyc);
    check("single_beats", vcyc, NB);
    check("single_pops", pop_cnt, 1);
    check("single_word_cnt", word_cnt, 16'd1);
    check("single_busy_after", busy, 1'b0);

    // Back-to-back: 16 random words, 128 contiguous beats.
    tick();
    en = 1'b0;
    for (int k = 0; k < 16; k++) push_word({$urandom(), $urandom()});
    tick();
    pops0 = pop_cnt;
    en = 1'b1;
    run_word_phase("b2b", 400, vcyc);
    check("b2b_contiguous_beats", vcyc, 16 * NB);
    check("b2b_pops", pop_cnt - pops0, 16);
    check("b2b_word_cnt", word_cnt, 16'd17);
    check("b2b_fifo_empty", fifo_empty, 1'b1);

    // Backpressure: ready 1,0,0,1 then random.
    tick();
    en = 1'b0;
    for (int k = 0; k < 6; k++) push_word({$urandom(), $urandom()});
    tick();
    en = 1'b1;
    for (i = 0; i < 600; i++) begin
      case (i % 4)
        0, 3:    out_ready = (i < 4) ? 1'b1 : 1'(($urandom() % 3) != 0);
        default: out_ready = (i < 4) ? 1'b0 : 1'($urandom() % 2);
      endcase
      tick();
      if (i > 4 && fifo_empty && !busy) break;
    end
    out_ready = 1'b1;
    if (i >= 600) begin
      checks++;
      fails++;
      $display("FAIL bp_timeout: got still busy, expected drained within 600 cycles");
    end
    @(negedge clk);
    check("bp_word_cnt", word_cnt, 16'd23);

    // en dropped after beat 3: current word completes, rest stays queued.
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) push_word({$urandom(), $urandom()});
    tick();
    en = 1'b1;
    wait_beats(3, 50);
    @(posedge clk);
    #1;
    en = 1'b0;
    run_word_phase("en_drop", 50, vcyc);
    repeat (3) @(negedge clk);
    check("en_drop_busy", busy, 1'b0);
    check("en_drop_fifo_left", fifo_q.size(), 2);
    check("en_drop_word_cnt", word_cnt, 16'd24);

    // Reset in the middle of a word.
    tick();
    en = 1'b1;
    wait_beats(4, 50);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_last", out_last, 1'b0);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rd_en", fifo_rd_en, 1'b0);
    check("mid_rst_word_cnt", word_cnt, 16'h0000);
    repeat (2) tick();
    check("mid_rst_no_pop", fifo_q.size(), 1);
    rst_n = 1'b1;
    run_word_phase("after_rst", 50, vcyc);
    check("after_rst_beats", vcyc, NB);
    check("after_rst_word_cnt", word_cnt, 16'd1);

    // Counter wrap from 0xFFFF.
    tick();
    en = 1'b0;
    @(negedge clk);
    force dut.word_cnt_d = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.word_cnt_d;
    model_cnt = 16'hFFFF;
    push_word({$urandom(), $urandom()});
    tick();
    en = 1'b1;
    run_word_phase("wrap", 50, vcyc);
    check("wrap_word_cnt", word_cnt, 16'h0000);
    check("all_words_sent", exp_q.size(), 0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #300000;
    checks++;
    fails++;
    $display("FAIL global_timeout: got no finish, expected end before 300000");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
